multicycle_sequencer: RTL and testbench

- Multi-cycle FSM that sequences the KGP mini-RISC datapath: fetch, decode, execute, memory, write-back.
- Consumes the decoded control word (reg_write, dmem_enable, dmem_write_enable, br_op) and gates PC, IR, register-file and data-memory enables per phase.
- Handles ready-handshakes with instruction and data memory, with a data-memory watchdog.
- Counts retired instructions and stops on a HALT opcode.

---
 rtl/multicycle_sequencer.sv | 166 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the KGP mini-RISC datapath: FETCH, DECODE, EXEC, MEM, WB.
// Gates the PC, IR, register-file and data-memory enables, runs a data-memory watchdog
// and counts retired instructions.
module multicycle_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'd63,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [1:0]       reg_write,
    input  logic             dmem_enable,
    input  logic             dmem_write_enable,
    input  logic [4:0]       br_op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_en,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             rf_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int               WD_W    = $clog2(MEM_TIMEOUT + 1);
    // Last cycle of the wait window: the watchdog counts 0..MEM_TIMEOUT-1.
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q;
    logic              wd_clr, wd_inc, set_err;
    logic              retire;
    logic              mem_err_q;
    logic [CNT_W-1:0]  instr_count_q;

    // NOTE: async active-low reset, and <= only in clocked blocks so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q          <= '0;
            mem_err_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            if (wd_clr) begin
                wd_q <= '0;
            end else if (wd_inc) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (set_err) begin
                mem_err_q <= 1'b1;
            end
            if (retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        set_err = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (dmem_enable) begin
                    state_d = S_MEM;
                    wd_clr  = 1'b1;
                end else if (br_op != 5'd0) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready in the final watchdog cycle still completes the access.
                if (dmem_ready) begin
                    state_d = dmem_write_enable ? S_FETCH : S_WB;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_HALT;
                    set_err = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        imem_en  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_en  = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                if (!dmem_enable && (br_op != 5'd0)) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    rf_we    = (reg_write == 2'b11);
                    retire   = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dmem_write_enable;
                if (dmem_ready && dmem_write_enable) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            S_WB: begin
                rf_we    = (reg_write != 2'b00);
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign mem_err     = mem_err_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: inputs change and outputs are checked on the
// falling edge, state advances on the rising edge.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [1:0]  reg_write = '0;
    logic        dmem_enable = 1'b0;
    logic        dmem_write_enable = 1'b0;
    logic [4:0]  br_op = '0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_en, ir_write, pc_write, pc_sel, rf_we, dmem_req, dmem_we;
    logic [2:0]  state;
    logic        busy, halted, mem_err;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(
        .HALT_OPCODE(6'd63),
        .MEM_TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .reg_write(reg_write), .dmem_enable(dmem_enable),
        .dmem_write_enable(dmem_write_enable), .br_op(br_op),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_en(imem_en), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .state(state), .busy(busy), .halted(halted), .mem_err(mem_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: advance on the rising edge, land on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ctrl(input logic [5:0] op, input logic [1:0] rw, input logic de,
                        input logic dwe, input logic [4:0] br);
        opcode            = op;
        reg_write         = rw;
        dmem_enable       = de;
        dmem_write_enable = dwe;
        br_op             = br;
    endtask

    // Enables packed as {imem_en, ir_write, pc_write, pc_sel, rf_we, dmem_req, dmem_we}.
    function automatic logic [31:0] enables();
        return {25'd0, imem_en, ir_write, pc_write, pc_sel, rf_we, dmem_req, dmem_we};
    endfunction

    // Reset, then start: returns on the falling edge with the DUT in FETCH.
    task automatic reset_and_start();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_enables", enables(), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_fetch", 32'(state), 32'd1);
    endtask

    initial begin
        int n;

        // Test 1: ALU add, F D E W F.
        reset_and_start();
        ctrl(6'd1, 2'b01, 1'b0, 1'b0, 5'd0);
        #1;
        check("add_fetch_en", enables(), 32'b1100000);
        check("add_busy", 32'(busy), 32'd1);
        cyc();
        check("add_decode", 32'(state), 32'd2);
        check("add_decode_en", enables(), 32'd0);
        cyc();
        check("add_exec", 32'(state), 32'd3);
        check("add_exec_en", enables(), 32'd0);
        cyc();
        check("add_wb", 32'(state), 32'd5);
        check("add_wb_en", enables(), 32'b0010100);
        cyc();
        check("add_back_fetch", 32'(state), 32'd1);
        check("add_count", instr_count, 32'd1);

        // Test 2: lw with three not-ready cycles, then lw ready on the 16th MEM cycle.
        reset_and_start();
        ctrl(6'd2, 2'b10, 1'b1, 1'b0, 5'd0);
        dmem_ready = 1'b0;
        cyc();
        cyc();
        check("lw_exec_en", enables(), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) dmem_ready = 1'b1;
            #1;
            check($sformatf("lw_mem%0d_state", i), 32'(state), 32'd4);
            check($sformatf("lw_mem%0d_en", i), enables(), 32'b0000010);
        end
        cyc();
        check("lw_wb", 32'(state), 32'd5);
        check("lw_wb_en", enables(), 32'b0010100);
        cyc();
        check("lw_count", instr_count, 32'd1);
        dmem_ready = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 15) dmem_ready = 1'b1;
            #1;
            check($sformatf("lw16_mem%0d", i), 32'(state), 32'd4);
        end
        cyc();
        check("lw16_wb", 32'(state), 32'd5);
        check("lw16_no_err", 32'(mem_err), 32'd0);
        cyc();
        check("lw16_count", instr_count, 32'd2);

        // Test 3: bl (retires from EXEC), then sw (retires from MEM).
        reset_and_start();
        ctrl(6'd3, 2'b11, 1'b0, 1'b0, 5'b00101);
        cyc();
        cyc();
        check("bl_exec", 32'(state), 32'd3);
        check("bl_exec_en", enables(), 32'b0011100);
        cyc();
        check("bl_fetch", 32'(state), 32'd1);
        check("bl_count", instr_count, 32'd1);
        ctrl(6'd4, 2'b00, 1'b1, 1'b1, 5'd0);
        cyc();
        cyc();
        check("sw_exec_en", enables(), 32'd0);
        cyc();
        check("sw_mem", 32'(state), 32'd4);
        check("sw_mem_en", enables(), 32'b0010011);
        cyc();
        check("sw_fetch", 32'(state), 32'd1);
        check("sw_count", instr_count, 32'd2);

        // Test 4: dmem_ready stuck low, watchdog halts after exactly 16 MEM cycles.
        reset_and_start();
        ctrl(6'd2, 2'b10, 1'b1, 1'b0, 5'd0);
        dmem_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        n = 0;
        while (state == 3'd4 && n < 40) begin
            n++;
            cyc();
        end
        check("wd_mem_cycles", 32'(n), 32'd16);
        check("wd_halt", 32'(state), 32'd6);
        check("wd_mem_err", 32'(mem_err), 32'd1);
        check("wd_halted", 32'(halted), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        start = 1'b1;
        dmem_ready = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        check("wd_start_ignored", 32'(state), 32'd6);
        check("wd_halt_en", enables(), 32'd0);
        check("wd_count", instr_count, 32'd0);

        // Test 5: five retired instructions (ALU and NOP), then HALT opcode.
        reset_and_start();
        for (int k = 0; k < 5; k++) begin
            ctrl(6'd5, (k % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, 5'd0);
            cyc();
            cyc();
            cyc();
            check($sformatf("seq%0d_wb_en", k), enables(),
                  (k % 2 == 0) ? 32'b0010100 : 32'b0010000);
            cyc();
        end
        check("seq_count", instr_count, 32'd5);
        ctrl(6'd63, 2'b01, 1'b0, 1'b0, 5'd0);
        cyc();
        check("halt_decode", 32'(state), 32'd2);
        cyc();
        check("halt_state", 32'(state), 32'd6);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_en", enables(), 32'd0);
        check("halt_mem_err", 32'(mem_err), 32'd0);
        cyc();
        check("halt_count", instr_count, 32'd5);

        // Test 6: asynchronous reset in the middle of a data access.
        reset_and_start();
        ctrl(6'd1, 2'b01, 1'b0, 1'b0, 5'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        check("pre_count", instr_count, 32'd1);
        ctrl(6'd2, 2'b10, 1'b1, 1'b0, 5'd0);
        dmem_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        cyc();
        check("mid_mem_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_req_drop", 32'(dmem_req), 32'd0);
        check("async_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_count", instr_count, 32'd0);
        check("post_rst_mem_err", 32'(mem_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
